parity_err_monitor: RTL and testbench

PARITY_ERR_MONITOR -- requirements
Module: parity_err_monitor

---
 rtl/parity_err_monitor.sv | 121 ++++++++++++
 tb/tb_parity_err_monitor.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_err_monitor.sv
// Parity checker that folds a 32-bit word one byte per cycle and tracks error statistics.
// Define PARITY_MON_STATS_EN to build the word_count statistics counter; otherwise word_count is tied to 0.
module parity_err_monitor #(
    parameter int THRESH = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_par,
    input  logic             cfg_odd,
    input  logic             clr,
    output logic             out_valid,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    output logic             alarm,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  beat;
    logic [31:0] data_q;
    logic        par_q;
    logic        odd_q;
    logic [7:0]  acc;
    logic [7:0]  consec;
    logic [7:0]  consec_inc;
    logic        mismatch;
    logic        done_exit;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (beat == 2'd3) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign done_exit  = (state == DONE);
    assign mismatch   = ((^acc) ^ par_q) != odd_q;
    assign out_err    = out_valid && mismatch;
    assign consec_inc = (consec == 8'hFF) ? consec : consec + 8'd1;

    // The latched word is shifted down so byte 0 is always folded first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            beat   <= 2'd0;
            data_q <= 32'd0;
            par_q  <= 1'b0;
            odd_q  <= 1'b0;
            acc    <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        par_q  <= in_par;
                        odd_q  <= cfg_odd;
                        acc    <= 8'd0;
                        beat   <= 2'd0;
                    end
                end
                CALC: begin
                    acc    <= acc ^ data_q[7:0];
                    data_q <= data_q >> 8;
                    beat   <= beat + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // clr outranks the DONE-exit update so a coincident clear leaves everything at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count <= '0;
            consec    <= 8'd0;
            alarm     <= 1'b0;
        end else if (clr) begin
            err_count <= '0;
            consec    <= 8'd0;
            alarm     <= 1'b0;
        end else if (done_exit) begin
            if (mismatch) begin
                if (!(&err_count)) err_count <= err_count + CNT_W'(1);
                consec <= consec_inc;
                if (consec_inc >= 8'(THRESH)) alarm <= 1'b1;
            end else begin
                consec <= 8'd0;
            end
        end
    end

`ifdef PARITY_MON_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            word_count <= '0;
        end else if (done_exit && !(&word_count)) begin
            word_count <= word_count + CNT_W'(1);
        end
    end
`else
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_parity_err_monitor.sv
// Directed bench for parity_err_monitor built with THRESH=3 and a narrow CNT_W=4 so saturation is reachable.
module tb_parity_err_monitor;

    localparam int THRESH = 3;
    localparam int CNT_W  = 4;

`ifdef PARITY_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_par;
    logic             cfg_odd;
    logic             clr;
    logic             out_valid;
    logic             out_err;
    logic [CNT_W-1:0] err_count;
    logic             alarm;
    logic [CNT_W-1:0] word_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    parity_err_monitor #(.THRESH(THRESH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_par     (in_par),
        .cfg_odd    (cfg_odd),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_err    (out_err),
        .err_count  (err_count),
        .alarm      (alarm),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Sends one word, scrambles the inputs while it is in flight, and returns after the DONE-exit edge.
    task automatic drive_word(input logic [31:0] d, input logic p, input logic o,
                              output int lat, output logic err, output logic timed_out);
        int waitc;
        lat = 0;
        err = 1'b0;
        timed_out = 1'b0;
        in_data = d;
        in_par = p;
        cfg_odd = o;
        in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        if (!in_ready) begin
            timed_out = 1'b1;
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_data = ~d;
        in_par = ~p;
        cfg_odd = ~o;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
            in_data = $urandom;
        end
        if (!out_valid) begin
            timed_out = 1'b1;
            return;
        end
        err = out_err;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        clr = 1'b0;
        in_data = 32'd0;
        in_par = 1'b0;
        cfg_odd = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_compared++;
        if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_compared++;
        if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_compared++;
        if (out_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); end
        n_compared++;
        if (err_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_err_count: got %0d expected 0", err_count); end
        n_compared++;
        if (alarm !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_alarm: got %b expected 0", alarm); end
        n_compared++;
        if (word_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_word_count: got %0d expected 0", word_count); end
    endtask

    task automatic test_basic();
        int lat;
        logic err, to;
        drive_word(32'd45, 1'b0, 1'b0, lat, err, to);
        n_compared++;
        if (to !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_timeout: got %b expected 0", to); end
        n_compared++;
        if (lat != 5) begin n_mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 5", lat); end
        n_compared++;
        if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_out_err: got %b expected 0", err); end
        n_compared++;
        if (err_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL basic_err_count: got %0d expected 0", err_count); end
        n_compared++;
        if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_mismatch();
        int lat;
        logic err, to;
        drive_word(32'd45, 1'b1, 1'b0, lat, err, to);
        n_compared++;
        if (err !== 1'b1 || to !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mismatch_even: got err=%b to=%b expected err=1 to=0", err, to); end
        n_compared++;
        if (err_count !== 4'd1) begin n_mismatched++; $display("[TB] FAIL mismatch_count1: got %0d expected 1", err_count); end
        drive_word(32'd45, 1'b0, 1'b1, lat, err, to);
        n_compared++;
        if (err !== 1'b1 || to !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mismatch_odd: got err=%b to=%b expected err=1 to=0", err, to); end
        n_compared++;
        if (err_count !== 4'd2) begin n_mismatched++; $display("[TB] FAIL mismatch_count2: got %0d expected 2", err_count); end
    endtask

    task automatic test_alarm();
        int lat;
        logic err, to;
        logic exp_alarm [3];
        exp_alarm[0] = 1'b0;
        exp_alarm[1] = 1'b0;
        exp_alarm[2] = 1'b1;
        pulse_clr();
        n_compared++;
        if (err_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL alarm_clr_first: got %0d expected 0", err_count); end
        for (int i = 0; i < 3; i++) begin
            drive_word(32'd45, 1'b1, 1'b0, lat, err, to);
            n_compared++;
            if (alarm !== exp_alarm[i] || to !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL alarm_step%0d: got alarm=%b to=%b expected alarm=%b to=0", i, alarm, to, exp_alarm[i]);
            end
        end
        n_compared++;
        if (err_count !== 4'd3) begin n_mismatched++; $display("[TB] FAIL alarm_err_count: got %0d expected 3", err_count); end
        drive_word(32'd45, 1'b0, 1'b0, lat, err, to);
        n_compared++;
        if (alarm !== 1'b1 || err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL alarm_sticky: got alarm=%b err=%b expected alarm=1 err=0", alarm, err); end
        pulse_clr();
        n_compared++;
        if (alarm !== 1'b0) begin n_mismatched++; $display("[TB] FAIL alarm_cleared: got %b expected 0", alarm); end
        n_compared++;
        if (err_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL alarm_clr_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        pulse_reset();
        in_data = 32'd45;
        in_par = 1'b1;
        cfg_odd = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_compared++;
        if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_compared++;
        if (seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstmid_out_valid: got %b expected 0", seen); end
        n_compared++;
        if (err_count !== 4'd0 || alarm !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstmid_counters: got err_count=%0d alarm=%b expected 0/0", err_count, alarm); end
        n_compared++;
        if (word_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL rstmid_word_count: got %0d expected 0", word_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        logic        p [4];
        logic        exp_err [4];
        logic        res [4];
        int          acc_cyc [4];
        int          idx, nres, guard;
        logic        fire;
        w[0] = 32'd45;  p[0] = 1'b0; exp_err[0] = 1'b0;
        w[1] = 32'd45;  p[1] = 1'b1; exp_err[1] = 1'b1;
        w[2] = 32'h1;   p[2] = 1'b0; exp_err[2] = 1'b1;
        w[3] = 32'h3;   p[3] = 1'b0; exp_err[3] = 1'b0;
        pulse_reset();
        cfg_odd = 1'b0;
        idx = 0;
        nres = 0;
        guard = 0;
        while (nres < 4 && guard < 80) begin
            in_valid = (idx < 4);
            fire = in_ready && (idx < 4);
            if (fire) begin
                in_data = w[idx];
                in_par = p[idx];
            end else begin
                in_data = $urandom;
                in_par = 1'($urandom);
            end
            if (out_valid) begin
                res[nres] = out_err;
                nres++;
            end
            tick();
            guard++;
            if (fire) begin
                acc_cyc[idx] = guard;
                idx++;
            end
        end
        in_valid = 1'b0;
        n_compared++;
        if (nres != 4) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_results: got %0d expected 4", nres);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_compared++;
                if (res[i] !== exp_err[i]) begin n_mismatched++; $display("[TB] FAIL b2b_err%0d: got %b expected %b", i, res[i], exp_err[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                n_compared++;
                if (acc_cyc[i+1] - acc_cyc[i] != 6) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_gap%0d: got %0d expected 6", i, acc_cyc[i+1] - acc_cyc[i]);
                end
            end
        end
        n_compared++;
        if (err_count !== 4'd2) begin n_mismatched++; $display("[TB] FAIL b2b_err_count: got %0d expected 2", err_count); end
        n_compared++;
        if (word_count !== (STATS ? 4'd4 : 4'd0)) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_word_count: got %0d expected %0d", word_count, STATS ? 4 : 0);
        end
    endtask

    task automatic test_saturation();
        int lat, n_to;
        logic err, to;
        pulse_reset();
        n_to = 0;
        for (int i = 1; i <= 16; i++) begin
            drive_word(32'hA5A5_0001, 1'b0, 1'b0, lat, err, to);
            if (to) n_to++;
            if (i == 15) begin
                n_compared++;
                if (err_count !== 4'hF) begin n_mismatched++; $display("[TB] FAIL sat_at15: got %0h expected f", err_count); end
            end
        end
        n_compared++;
        if (n_to != 0) begin n_mismatched++; $display("[TB] FAIL sat_timeouts: got %0d expected 0", n_to); end
        n_compared++;
        if (err_count !== 4'hF) begin n_mismatched++; $display("[TB] FAIL sat_hold: got %0h expected f", err_count); end
        n_compared++;
        if (alarm !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_alarm: got %b expected 1", alarm); end
        n_compared++;
        if (word_count !== (STATS ? 4'hF : 4'h0)) begin
            n_mismatched++;
            $display("[TB] FAIL sat_word_count: got %0h expected %0h", word_count, STATS ? 4'hF : 4'h0);
        end
    endtask

    // clr lands on the DONE-exit edge of a mismatching word.
    task automatic test_clr_coincident();
        int waitc;
        in_data = 32'd45;
        in_par = 1'b1;
        cfg_odd = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waitc = 0;
        while (!out_valid && waitc < 20) begin
            tick();
            waitc++;
        end
        clr = 1'b1;
        n_compared++;
        if (out_valid !== 1'b1 || out_err !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL clrco_strobe: got valid=%b err=%b expected 1/1", out_valid, out_err);
        end
        tick();
        clr = 1'b0;
        n_compared++;
        if (err_count !== 4'd0 || alarm !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL clrco_counters: got err_count=%0d alarm=%b expected 0/0", err_count, alarm);
        end
        n_compared++;
        if (word_count !== (STATS ? 4'hF : 4'h0)) begin
            n_mismatched++;
            $display("[TB] FAIL clrco_word_count: got %0h expected %0h", word_count, STATS ? 4'hF : 4'h0);
        end
        n_compared++;
        if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL clrco_in_ready: got %b expected 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_alarm();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        test_clr_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
